mem_arbiter: RTL and testbench

Arbitrates the single line-wide main-memory port (`mem_req`/`WriteEnable`/`memory_address`/`mem_writedata`/`mem_readdata`/`mem_ready`) between the instruction-cache refill path and the data-cache refill/writeback path. It sits between the two caches and `datamem`. The arbiter grants one requester at a time and registers the granted request. It then holds the memory handshake until `mem_ready` and returns the line to the winner with a one-cycle ready pulse.

---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Purpose: arbitrates one line-wide memory port between I-cache refill and D-cache refill/writeback (optional round-robin: MEM_ARB_ROUND_ROBIN_EN).
// Latency: grant one edge after a request in IDLE; owner ready pulses one edge after mem_ready; 3 cycles minimum per transaction.
// Backpressure: requests are sampled only in IDLE; a losing requester simply holds req until its own ready pulse.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_ready,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_ready,
    output logic                  mem_req,
    output logic                  WriteEnable,
    output logic [ADDR_WIDTH-1:0] memory_address,
    output logic [LINE_WIDTH-1:0] mem_writedata,
    input  logic [LINE_WIDTH-1:0] mem_readdata,
    input  logic                  mem_ready,
    output logic                  busy
);

    // Byte-offset bits inside one line; these are cleared on the captured address.
    localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~(ADDR_WIDTH'((1 << OFFSET_BITS) - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arbState_t;

    arbState_t             state;
    arbState_t             nextState;
    logic                  ownerD;      // 1: data side owns the transaction in flight
    logic                  grantAny;
    logic                  grantD;
    logic                  capWe;
    logic [ADDR_WIDTH-1:0] capAddr;
    logic [LINE_WIDTH-1:0] capWdata;
    logic [LINE_WIDTH-1:0] iRdataQ;
    logic [LINE_WIDTH-1:0] dRdataQ;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                  lastServedD; // 0: instruction side was served last

    // Winner selection: on a tie, serve the side that was not served last.
    always_comb begin
        grantAny = i_req | d_req;
        grantD   = d_req & (~i_req | ~lastServedD);
    end

    // Last-served pointer moves on every grant; reset favours the data side next.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lastServedD <= 1'b0;
        end else if ((state == IDLE) && grantAny) begin
            lastServedD <= grantD;
        end
    end
`else
    // Winner selection: data side has fixed priority over instruction side.
    always_comb begin
        grantAny = i_req | d_req;
        grantD   = d_req;
    end
`endif

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state: IDLE -> BUSY on any request, BUSY -> RESP on mem_ready, RESP -> IDLE.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (grantAny) begin
                    nextState = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    nextState = RESP;
                end
            end
            RESP: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Capture the winner's request so the memory side sees stable values for all of BUSY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ownerD   <= 1'b0;
            capWe    <= 1'b0;
            capAddr  <= '0;
            capWdata <= '0;
        end else if ((state == IDLE) && grantAny) begin
            ownerD <= grantD;
            if (grantD) begin
                capWe    <= d_we;
                capAddr  <= d_addr & LINE_MASK;
                capWdata <= d_wdata;
            end else begin
                capWe    <= 1'b0;
                capAddr  <= i_addr & LINE_MASK;
                capWdata <= '0;
            end
        end
    end

    // Return data lands only in the owner's register, and only for reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iRdataQ <= '0;
            dRdataQ <= '0;
        end else if ((state == BUSY) && mem_ready && !capWe) begin
            if (ownerD) begin
                dRdataQ <= mem_readdata;
            end else begin
                iRdataQ <= mem_readdata;
            end
        end
    end

    // Outputs are registers or pure decodes of state, so no input reaches an output combinationally.
    assign mem_req        = (state == BUSY);
    assign WriteEnable    = (state == BUSY) && capWe;
    assign memory_address = capAddr;
    assign mem_writedata  = capWdata;
    assign i_ready        = (state == RESP) && !ownerD;
    assign d_ready        = (state == RESP) && ownerD;
    assign i_rdata        = iRdataQ;
    assign d_rdata        = dRdataQ;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: randomized and directed bench for mem_arbiter against a transaction-level model.
// Latency: model expects grant one edge after IDLE sampling and ready one edge after mem_ready.
// Backpressure: requesters hold req until their ready pulse; the bench acts as datamem.
module tb_mem_arbiter;

    logic         clk;
    logic         rst;
    logic         i_req;
    logic [31:0]  i_addr;
    logic [127:0] i_rdata;
    logic         i_ready;
    logic         d_req;
    logic         d_we;
    logic [31:0]  d_addr;
    logic [127:0] d_wdata;
    logic [127:0] d_rdata;
    logic         d_ready;
    logic         mem_req;
    logic         WriteEnable;
    logic [31:0]  memory_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_ready;
    logic         busy;

    int nChecks = 0;
    int nPass   = 0;

    // Transaction-level reference state.
    bit           pendI;
    bit           pendD;
    logic [31:0]  pIAddr;
    logic [31:0]  pDAddr;
    logic         pDWe;
    logic [127:0] pDWd;
    logic [127:0] expIRdata;
    logic [127:0] expDRdata;
    bit           lastD;

    mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .i_rdata        (i_rdata),
        .i_ready        (i_ready),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_rdata        (d_rdata),
        .d_ready        (d_ready),
        .mem_req        (mem_req),
        .WriteEnable    (WriteEnable),
        .memory_address (memory_address),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata),
        .mem_ready      (mem_ready),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic resetModel();
        pendI     = 1'b0;
        pendD     = 1'b0;
        pIAddr    = '0;
        pDAddr    = '0;
        pDWe      = 1'b0;
        pDWd      = '0;
        expIRdata = '0;
        expDRdata = '0;
        lastD     = 1'b0;
    endtask

    // One complete transaction: post new requests, check grant, hold, response and return to IDLE.
    task automatic doTxn(input bit newI, input bit newD, input logic [31:0] ia, input logic [31:0] da,
                         input logic dwe, input logic [127:0] dwd, input int lat, input logic [127:0] rline);
        bit           winD;
        logic [31:0]  eAddr;
        logic         eWe;
        logic [127:0] eWd;
        @(negedge clk);
        if (newI && !pendI) begin
            pendI  = 1'b1;
            pIAddr = ia;
        end
        if (newD && !pendD) begin
            pendD  = 1'b1;
            pDAddr = da;
            pDWe   = dwe;
            pDWd   = dwd;
        end
        i_req   = pendI;
        i_addr  = pIAddr;
        d_req   = pendD;
        d_addr  = pDAddr;
        d_we    = pDWe;
        d_wdata = pDWd;
        if (!pendI && !pendD) return;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        winD = pendD && (!pendI || !lastD);
`else
        winD = pendD;
`endif
        lastD = winD;
        eAddr = winD ? pDAddr : pIAddr;
        eAddr = {eAddr[31:4], 4'h0};
        eWe   = winD ? pDWe : 1'b0;
        eWd   = winD ? pDWd : 128'd0;

        @(posedge clk); #1;
        check("grant_mem_req", 128'(mem_req), 128'(1'b1));
        check("grant_busy", 128'(busy), 128'(1'b1));
        check("grant_addr", 128'(memory_address), 128'(eAddr));
        check("grant_we", 128'(WriteEnable), 128'(eWe));
        check("grant_wdata", mem_writedata, eWd);
        // The winner's inputs may wander once captured; the memory side must not follow.
        if (winD) begin
            d_addr  = $urandom;
            d_wdata = rand128();
            d_we    = ~d_we;
        end else begin
            i_addr = $urandom;
        end

        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            @(posedge clk); #1;
            check("hold_mem_req", 128'(mem_req), 128'(1'b1));
            check("hold_addr", 128'(memory_address), 128'(eAddr));
            check("hold_we", 128'(WriteEnable), 128'(eWe));
            check("hold_wdata", mem_writedata, eWd);
            check("hold_no_ready", 128'({i_ready, d_ready}), 128'(2'b00));
        end

        @(negedge clk);
        mem_ready    = 1'b1;
        mem_readdata = rline;
        @(posedge clk); #1;
        mem_ready    = 1'b0;
        mem_readdata = rand128();
        if (!eWe) begin
            if (winD) expDRdata = rline;
            else      expIRdata = rline;
        end
        check("resp_i_ready", 128'(i_ready), 128'(!winD));
        check("resp_d_ready", 128'(d_ready), 128'(winD));
        check("resp_i_rdata", i_rdata, expIRdata);
        check("resp_d_rdata", d_rdata, expDRdata);
        check("resp_mem_req", 128'(mem_req), 128'(1'b0));
        check("resp_busy", 128'(busy), 128'(1'b1));

        @(negedge clk);
        if (winD) begin
            pendD = 1'b0;
            d_req = 1'b0;
        end else begin
            pendI = 1'b0;
            i_req = 1'b0;
        end
        @(posedge clk); #1;
        check("idle_ready", 128'({i_ready, d_ready}), 128'(2'b00));
        check("idle_busy", 128'(busy), 128'(1'b0));
        check("idle_i_rdata", i_rdata, expIRdata);
        check("idle_d_rdata", d_rdata, expDRdata);
    endtask

    // mem_ready while IDLE must be ignored completely.
    task automatic strayReady();
        @(negedge clk);
        mem_ready    = 1'b1;
        mem_readdata = rand128();
        @(posedge clk); #1;
        mem_ready = 1'b0;
        check("stray_busy", 128'(busy), 128'(1'b0));
        check("stray_ready", 128'({i_ready, d_ready}), 128'(2'b00));
        check("stray_i_rdata", i_rdata, expIRdata);
        check("stray_d_rdata", d_rdata, expDRdata);
        @(posedge clk); #1;
        check("stray_after", 128'({busy, i_ready, d_ready, mem_req}), 128'(4'b0000));
    endtask

    initial begin
        rst          = 1'b0;
        i_req        = 1'b0;
        i_addr       = '0;
        d_req        = 1'b0;
        d_we         = 1'b0;
        d_addr       = '0;
        d_wdata      = '0;
        mem_readdata = '0;
        mem_ready    = 1'b0;
        resetModel();

        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl", 128'({mem_req, WriteEnable, i_ready, d_ready, busy}), 128'(5'b00000));
        check("rst_addr", 128'(memory_address), 128'd0);
        check("rst_wdata", mem_writedata, 128'd0);
        check("rst_rdata", i_rdata | d_rdata, 128'd0);
        @(negedge clk);
        rst = 1'b1;

        // Reset in the middle of a data-side transaction.
        @(negedge clk);
        d_req  = 1'b1;
        d_addr = 32'h0000_1234;
        d_we   = 1'b0;
        @(posedge clk); #1;
        check("midrst_grant", 128'(mem_req), 128'(1'b1));
        check("midrst_addr", 128'(memory_address), 128'(32'h0000_1230));
        #2;
        rst = 1'b0;
        #1;
        check("midrst_drop", 128'({mem_req, busy}), 128'(2'b00));
        check("midrst_addr0", 128'(memory_address), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_no_dready1", 128'(d_ready), 128'(1'b0));
        @(posedge clk); #1;
        check("midrst_regrant", 128'(mem_req), 128'(1'b1));
        check("midrst_no_dready2", 128'(d_ready), 128'(1'b0));
        @(negedge clk);
        d_req = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        resetModel();

        // Simultaneous requests straight after reset, then the loser drains.
        doTxn(1'b1, 1'b1, 32'h0000_2004, 32'h0000_3008, 1'b0, 128'd0, 1, rand128());
        doTxn(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 128'd0, 0, rand128());
        // Both held high repeatedly: fixed priority keeps D, round-robin alternates.
        for (int k = 0; k < 4; k++) begin
            doTxn(1'b1, 1'b1, 32'h0000_4000 + 32'(k * 16), 32'h0000_5000 + 32'(k * 16), 1'b0, 128'd0, 0, rand128());
        end
        while (pendI || pendD) doTxn(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 128'd0, 0, rand128());

        // Single instruction read with three BUSY cycles before mem_ready.
        doTxn(1'b1, 1'b0, 32'hBFC0_0014, 32'h0, 1'b0, 128'd0, 2,
              128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
        // Data writeback: d_rdata must stay as it was.
        doTxn(1'b0, 1'b1, 32'h0, 32'h0001_0008, 1'b1, {4{32'h1111_1111}}, 2, rand128());
        strayReady();

        // Randomized traffic.
        for (int t = 0; t < 200; t++) begin
            bit ni;
            bit nd;
            ni = 1'($urandom_range(0, 1));
            nd = 1'($urandom_range(0, 1));
            if (!pendI && !pendD && ($urandom_range(0, 7) == 0)) strayReady();
            if (!pendI && !pendD && !ni && !nd) ni = 1'b1;
            doTxn(ni, nd, $urandom, $urandom, 1'($urandom_range(0, 1)), rand128(),
                  int'($urandom_range(0, 3)), rand128());
        end
        while (pendI || pendD) doTxn(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 128'd0, 0, rand128());

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
